// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage. Issues a single registered data-bus
// transaction per load/store, stalls the pipeline until the bus completes or
// times out, then formats load data (big-endian lanes) for writeback.
module memory_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  in_dest_addr,
   input  logic        in_write_or_not,
   input  logic [31:0] in_wdata,
   input  logic        in_hilo_enabler,
   input  logic [31:0] in_hi,
   input  logic [31:0] in_lo,
   input  logic [3:0]  in_memop,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_store_data,
   output logic [4:0]  dest_addr,
   output logic        write_or_not,
   output logic [31:0] wdata,
   output logic        hilo_enabler,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stallreq,
   output logic        misalign_exc,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] MEMOP_LB  = 4'd1;
   localparam logic [3:0] MEMOP_LBU = 4'd2;
   localparam logic [3:0] MEMOP_LH  = 4'd3;
   localparam logic [3:0] MEMOP_LHU = 4'd4;
   localparam logic [3:0] MEMOP_LW  = 4'd5;
   localparam logic [3:0] MEMOP_SB  = 4'd6;
   localparam logic [3:0] MEMOP_SH  = 4'd7;
   localparam logic [3:0] MEMOP_SW  = 4'd8;

   // Last ACCESS cycle index before the watchdog gives up (16 cycles total)
   localparam logic [3:0] WDOG_LAST = 4'd15;

   state_t      r_state;
   logic [31:0] r_rdata_q;
   logic [3:0]  r_cnt;
   logic        r_err_q;

   logic        w_is_access;
   logic        w_is_store;
   logic        w_is_load;
   logic        w_aligned;
   logic [3:0]  w_sel;
   logic [31:0] w_store_wdata;
   logic [31:0] w_load_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // HILO request is never affected by the memory access
   assign hilo_enabler = in_hilo_enabler;
   assign hi           = in_hi;
   assign lo           = in_lo;

   // Decode memop: access class, alignment, byte lanes and replicated store data
   always_comb begin
      w_is_access   = 1'b0;
      w_is_store    = 1'b0;
      w_is_load     = 1'b0;
      w_aligned     = 1'b1;
      w_sel         = 4'b0000;
      w_store_wdata = 32'h0000_0000;
      case (in_memop)
         MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
            w_is_access = 1'b1;
            w_is_store  = (in_memop == MEMOP_SB);
            w_is_load   = (in_memop != MEMOP_SB);
            w_aligned   = 1'b1;
            w_sel       = 4'b1000 >> in_mem_addr[1:0];
            if (in_memop == MEMOP_SB) begin
               w_store_wdata = {4{in_store_data[7:0]}};
            end else begin
               w_store_wdata = 32'h0000_0000;
            end
         end
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
            w_is_access = 1'b1;
            w_is_store  = (in_memop == MEMOP_SH);
            w_is_load   = (in_memop != MEMOP_SH);
            w_aligned   = (in_mem_addr[0] == 1'b0);
            if (in_mem_addr[1] == 1'b1) begin
               w_sel = 4'b0011;
            end else begin
               w_sel = 4'b1100;
            end
            if (in_memop == MEMOP_SH) begin
               w_store_wdata = {2{in_store_data[15:0]}};
            end else begin
               w_store_wdata = 32'h0000_0000;
            end
         end
         MEMOP_LW, MEMOP_SW: begin
            w_is_access = 1'b1;
            w_is_store  = (in_memop == MEMOP_SW);
            w_is_load   = (in_memop == MEMOP_LW);
            w_aligned   = (in_mem_addr[1:0] == 2'b00);
            w_sel       = 4'b1111;
            if (in_memop == MEMOP_SW) begin
               w_store_wdata = in_store_data;
            end else begin
               w_store_wdata = 32'h0000_0000;
            end
         end
         default: begin
            w_is_access   = 1'b0;
            w_is_store    = 1'b0;
            w_is_load     = 1'b0;
            w_aligned     = 1'b1;
            w_sel         = 4'b0000;
            w_store_wdata = 32'h0000_0000;
         end
      endcase
   end

   // Extract the addressed big-endian lane from latched read data and extend it
   always_comb begin
      w_byte      = 8'h00;
      w_half      = 16'h0000;
      w_load_data = 32'h0000_0000;
      case (in_mem_addr[1:0])
         2'd0:    w_byte = r_rdata_q[31:24];
         2'd1:    w_byte = r_rdata_q[23:16];
         2'd2:    w_byte = r_rdata_q[15:8];
         2'd3:    w_byte = r_rdata_q[7:0];
         default: w_byte = 8'h00;
      endcase
      if (in_mem_addr[1] == 1'b1) begin
         w_half = r_rdata_q[15:0];
      end else begin
         w_half = r_rdata_q[31:16];
      end
      case (in_memop)
         MEMOP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
         MEMOP_LBU: w_load_data = {24'h00_0000, w_byte};
         MEMOP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
         MEMOP_LHU: w_load_data = {16'h0000, w_half};
         MEMOP_LW:  w_load_data = r_rdata_q;
         default:   w_load_data = 32'h0000_0000;
      endcase
   end

   // Access FSM: launch bus cycle, wait for ack or watchdog expiry, one DONE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0000_0000;
         bus_sel   <= 4'b0000;
         bus_wdata <= 32'h0000_0000;
         r_rdata_q <= 32'h0000_0000;
         r_cnt     <= 4'd0;
         r_err_q   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_access && w_aligned) begin
                  r_state   <= S_ACCESS;
                  bus_req   <= 1'b1;
                  bus_we    <= w_is_store;
                  bus_addr  <= {in_mem_addr[31:2], 2'b00};
                  bus_sel   <= w_sel;
                  bus_wdata <= w_store_wdata;
                  r_cnt     <= 4'd0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ACCESS: begin
               // ack takes priority over a simultaneous watchdog expiry
               if (bus_ack) begin
                  r_rdata_q <= bus_rdata;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  r_state   <= S_DONE;
               end else if (r_cnt == WDOG_LAST) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  r_err_q <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_err_q <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               bus_req <= 1'b0;
               bus_we  <= 1'b0;
               r_err_q <= 1'b0;
            end
         endcase
      end
   end

   // Writeback request, stall and exception outputs as a function of state
   always_comb begin
      dest_addr    = in_dest_addr;
      write_or_not = in_write_or_not;
      wdata        = in_wdata;
      stallreq     = 1'b0;
      misalign_exc = 1'b0;
      bus_err      = 1'b0;
      if (rst) begin
         stallreq     = 1'b0;
         misalign_exc = 1'b0;
         bus_err      = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_access && w_aligned) begin
                  // pipeline is held; suppress the write until DONE
                  stallreq     = 1'b1;
                  write_or_not = 1'b0;
               end else if (w_is_access) begin
                  misalign_exc = 1'b1;
                  write_or_not = 1'b0;
               end else begin
                  stallreq = 1'b0;
               end
            end
            S_ACCESS: begin
               stallreq     = 1'b1;
               write_or_not = 1'b0;
            end
            S_DONE: begin
               if (r_err_q) begin
                  bus_err      = 1'b1;
                  write_or_not = 1'b0;
               end else if (w_is_load) begin
                  wdata = w_load_data;
               end else begin
                  wdata = in_wdata;
               end
            end
            default: begin
               stallreq = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: table of directed load/store vectors plus
// hand-written reset and bus-ack corner sequences.
module tb_memory_access;

   logic        clk;
   logic        rst;
   logic [4:0]  in_dest_addr;
   logic        in_write_or_not;
   logic [31:0] in_wdata;
   logic        in_hilo_enabler;
   logic [31:0] in_hi;
   logic [31:0] in_lo;
   logic [3:0]  in_memop;
   logic [31:0] in_mem_addr;
   logic [31:0] in_store_data;
   logic [4:0]  dest_addr;
   logic        write_or_not;
   logic [31:0] wdata;
   logic        hilo_enabler;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        stallreq;
   logic        misalign_exc;
   logic        bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   memory_access dut (
      .clk             (clk),
      .rst             (rst),
      .in_dest_addr    (in_dest_addr),
      .in_write_or_not (in_write_or_not),
      .in_wdata        (in_wdata),
      .in_hilo_enabler (in_hilo_enabler),
      .in_hi           (in_hi),
      .in_lo           (in_lo),
      .in_memop        (in_memop),
      .in_mem_addr     (in_mem_addr),
      .in_store_data   (in_store_data),
      .dest_addr       (dest_addr),
      .write_or_not    (write_or_not),
      .wdata           (wdata),
      .hilo_enabler    (hilo_enabler),
      .hi              (hi),
      .lo              (lo),
      .bus_req         (bus_req),
      .bus_we          (bus_we),
      .bus_addr        (bus_addr),
      .bus_sel         (bus_sel),
      .bus_wdata       (bus_wdata),
      .bus_rdata       (bus_rdata),
      .bus_ack         (bus_ack),
      .stallreq        (stallreq),
      .misalign_exc    (misalign_exc),
      .bus_err         (bus_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  memop;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] iwdata;
      logic        iwnot;
      int          ack_dly;   // ACCESS cycle carrying ack; 0 = never ack
      logic [31:0] rdata;
      logic        e_mis;
      logic [31:0] e_baddr;
      logic [3:0]  e_sel;
      logic        e_we;
      logic [31:0] e_bwdata;
      logic [31:0] e_wdata;
      logic        e_wnot;
      logic        e_err;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   stall_cnt;
      int   req_cnt;
      int   exp_req;
      bit   done;
      bit   is_acc;
      @(posedge clk); #1;
      in_memop        = v.memop;
      in_mem_addr     = v.addr;
      in_store_data   = v.sdata;
      in_wdata        = v.iwdata;
      in_write_or_not = v.iwnot;
      in_dest_addr    = 5'(idx + 3);
      in_hilo_enabler = idx[0];
      in_hi           = 32'h1000_0000 + 32'(idx);
      in_lo           = 32'h2000_0000 + 32'(idx);
      bus_ack         = 1'b0;
      bus_rdata       = 32'h5A5A_5A5A;
      is_acc = (v.memop >= 4'd1) && (v.memop <= 4'd8) && !v.e_mis;
      @(negedge clk);
      chk($sformatf("v%0d hi", idx), hi, 32'h1000_0000 + 32'(idx));
      chk($sformatf("v%0d lo", idx), lo, 32'h2000_0000 + 32'(idx));
      chk($sformatf("v%0d misalign", idx), {31'd0, misalign_exc}, {31'd0, v.e_mis});
      if (!is_acc) begin
         chk($sformatf("v%0d idle_stall", idx), {31'd0, stallreq}, 32'd0);
         chk($sformatf("v%0d idle_wnot", idx), {31'd0, write_or_not}, {31'd0, v.e_wnot});
         chk($sformatf("v%0d idle_dest", idx), {27'd0, dest_addr}, 32'(idx + 3));
         if (!v.e_mis) begin
            chk($sformatf("v%0d idle_wdata", idx), wdata, v.e_wdata);
         end
         @(negedge clk);
         chk($sformatf("v%0d no_bus", idx), {31'd0, bus_req}, 32'd0);
         chk($sformatf("v%0d still_idle", idx), {31'd0, stallreq}, 32'd0);
         in_memop = 4'd0;
      end else begin
         stall_cnt = 0;
         req_cnt   = 0;
         done      = 1'b0;
         for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (stallreq) stall_cnt++;
            if (bus_req) begin
               req_cnt++;
               if (req_cnt == 1) begin
                  chk($sformatf("v%0d bus_addr", idx), bus_addr, v.e_baddr);
                  chk($sformatf("v%0d bus_sel", idx), {28'd0, bus_sel}, {28'd0, v.e_sel});
                  chk($sformatf("v%0d bus_we", idx), {31'd0, bus_we}, {31'd0, v.e_we});
                  if (v.e_we) begin
                     chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.e_bwdata);
                  end
               end
               if (v.ack_dly != 0 && req_cnt == v.ack_dly) begin
                  bus_ack   = 1'b1;
                  bus_rdata = v.rdata;
               end else begin
                  bus_ack   = 1'b0;
                  bus_rdata = 32'h5A5A_5A5A;
               end
            end else if (c > 0) begin
               bus_ack = 1'b0;
               chk($sformatf("v%0d done_err", idx), {31'd0, bus_err}, {31'd0, v.e_err});
               chk($sformatf("v%0d done_wnot", idx), {31'd0, write_or_not}, {31'd0, v.e_wnot});
               chk($sformatf("v%0d done_dest", idx), {27'd0, dest_addr}, 32'(idx + 3));
               if (!v.e_err) begin
                  chk($sformatf("v%0d done_wdata", idx), wdata, v.e_wdata);
               end
               done = 1'b1;
            end
         end
         if (!done) begin
            chk($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
         end
         exp_req = (v.ack_dly == 0) ? 16 : v.ack_dly;
         chk($sformatf("v%0d req_cycles", idx), 32'(req_cnt), 32'(exp_req));
         chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(exp_req + 1));
         in_memop = 4'd0;
         @(negedge clk);
         chk($sformatf("v%0d back_idle_stall", idx), {31'd0, stallreq}, 32'd0);
         chk($sformatf("v%0d back_idle_err", idx), {31'd0, bus_err}, 32'd0);
         chk($sformatf("v%0d back_idle_req", idx), {31'd0, bus_req}, 32'd0);
      end
   endtask

   initial begin
      //          memop  addr          sdata         iwdata        wnot ack rdata        mis   baddr         sel      we    bwdata        wdata         wnot  err
      vecs[0]  = '{4'd5,  32'h0000_0100, 32'h0,        32'h0,        1'b1, 2,  32'h1122_3344, 1'b0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'h1122_3344, 1'b1, 1'b0};
      vecs[1]  = '{4'd1,  32'h0000_0203, 32'h0,        32'h0,        1'b1, 1,  32'h0000_00F0, 1'b0, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,        32'hFFFF_FFF0, 1'b1, 1'b0};
      vecs[2]  = '{4'd2,  32'h0000_0203, 32'h0,        32'h0,        1'b1, 1,  32'h0000_00F0, 1'b0, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,        32'h0000_00F0, 1'b1, 1'b0};
      vecs[3]  = '{4'd7,  32'h0000_0012, 32'hABCD_1234, 32'h5555_AAAA, 1'b0, 1,  32'h0,        1'b0, 32'h0000_0010, 4'b0011, 1'b1, 32'h1234_1234, 32'h5555_AAAA, 1'b0, 1'b0};
      vecs[4]  = '{4'd5,  32'h0000_0102, 32'h0,        32'h7777_7777, 1'b1, 0,  32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[5]  = '{4'd5,  32'h0000_0104, 32'h0,        32'h0,        1'b1, 0,  32'h0,        1'b0, 32'h0000_0104, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
      vecs[6]  = '{4'd3,  32'h0000_0300, 32'h0,        32'h0,        1'b1, 3,  32'h8001_7FFF, 1'b0, 32'h0000_0300, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
      vecs[7]  = '{4'd4,  32'h0000_0302, 32'h0,        32'h0,        1'b1, 1,  32'h8001_F00F, 1'b0, 32'h0000_0300, 4'b0011, 1'b0, 32'h0,        32'h0000_F00F, 1'b1, 1'b0};
      vecs[8]  = '{4'd6,  32'h0000_0401, 32'h1234_56A5, 32'h0,        1'b0, 2,  32'h0,        1'b0, 32'h0000_0400, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0};
      vecs[9]  = '{4'd8,  32'h0000_0500, 32'hDEAD_BEEF, 32'h0000_0042, 1'b0, 1,  32'h0,        1'b0, 32'h0000_0500, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0000_0042, 1'b0, 1'b0};
      vecs[10] = '{4'd1,  32'h0000_0601, 32'h0,        32'h0,        1'b1, 1,  32'h1182_3344, 1'b0, 32'h0000_0600, 4'b0100, 1'b0, 32'h0,        32'hFFFF_FF82, 1'b1, 1'b0};
      vecs[11] = '{4'd0,  32'h0000_0003, 32'h0,        32'hCAFE_BABE, 1'b1, 0,  32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0};
      vecs[12] = '{4'd12, 32'h0000_0001, 32'h0,        32'h0123_4567, 1'b1, 0,  32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0123_4567, 1'b1, 1'b0};
      vecs[13] = '{4'd3,  32'h0000_0101, 32'h0,        32'h0,        1'b1, 0,  32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[14] = '{4'd5,  32'h0000_0700, 32'h0,        32'h0,        1'b1, 16, 32'h0BAD_F00D, 1'b0, 32'h0000_0700, 4'b1111, 1'b0, 32'h0,        32'h0BAD_F00D, 1'b1, 1'b0};
      vecs[15] = '{4'd2,  32'h0000_0900, 32'h0,        32'h0,        1'b1, 1,  32'h7F00_0000, 1'b0, 32'h0000_0900, 4'b1000, 1'b0, 32'h0,        32'h0000_007F, 1'b1, 1'b0};

      // Reset state, with a misaligned LW presented to check output gating
      rst             = 1'b1;
      in_dest_addr    = 5'd1;
      in_write_or_not = 1'b1;
      in_wdata        = 32'h0;
      in_hilo_enabler = 1'b0;
      in_hi           = 32'h0;
      in_lo           = 32'h0;
      in_memop        = 4'd5;
      in_mem_addr     = 32'h0000_0102;
      in_store_data   = 32'h0;
      bus_rdata       = 32'h0;
      bus_ack         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst bus_sel", {28'd0, bus_sel}, 32'd0);
      chk("rst bus_wdata", bus_wdata, 32'd0);
      chk("rst misalign", {31'd0, misalign_exc}, 32'd0);
      chk("rst bus_err", {31'd0, bus_err}, 32'd0);
      in_mem_addr = 32'h0000_0100;
      @(negedge clk);
      chk("rst stallreq", {31'd0, stallreq}, 32'd0);
      in_memop = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i], i);
      end

      // Reset while in ACCESS, then a late ack must be ignored
      @(posedge clk); #1;
      in_memop        = 4'd5;
      in_mem_addr     = 32'h0000_0800;
      in_wdata        = 32'h1357_9BDF;
      in_write_or_not = 1'b1;
      in_dest_addr    = 5'd9;
      @(negedge clk);
      chk("rstacc idle_stall", {31'd0, stallreq}, 32'd1);
      @(negedge clk);
      chk("rstacc in_access", {31'd0, bus_req}, 32'd1);
      rst      = 1'b1;
      in_memop = 4'd0;
      @(negedge clk);
      chk("rstacc req_drop", {31'd0, bus_req}, 32'd0);
      chk("rstacc stall_rst", {31'd0, stallreq}, 32'd0);
      rst       = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("rstacc req_after_ack", {31'd0, bus_req}, 32'd0);
      chk("rstacc stall_after_ack", {31'd0, stallreq}, 32'd0);
      chk("rstacc err_after_ack", {31'd0, bus_err}, 32'd0);
      chk("rstacc wdata", wdata, 32'h1357_9BDF);
      chk("rstacc wnot", {31'd0, write_or_not}, 32'd1);
      chk("rstacc bus_addr", bus_addr, 32'd0);

      // A subsequent normal access still works after the ignored ack
      run_vec(vecs[0], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
